// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite response codes and width helpers
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axi_lite_regs_if.sv
// rtl/axi_lite_regs_if.sv - AXI4-Lite slave front-end producing register-file strobes
module axi_lite_regs_if
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = strb_width(DATA_WIDTH)
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  axi_write_fire,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [STRB_WIDTH-1:0] wr_strb,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  logic                  aw_held_q, w_held_q, bvalid_q, fire_q, rvalid_q;
  logic [ADDR_WIDTH-1:0] awaddr_q, wr_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, wr_data_q, rdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q, wr_strb_q;
  logic                  aw_hs, w_hs, aw_have, w_have;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [STRB_WIDTH-1:0] strb_d;

  assign s_axi_awready = s_axi_aresetn & ~aw_held_q & ~bvalid_q;
  assign s_axi_wready  = s_axi_aresetn & ~w_held_q & ~bvalid_q;
  assign s_axi_arready = s_axi_aresetn & ~rvalid_q;

  assign aw_hs   = s_axi_awvalid & s_axi_awready;
  assign w_hs    = s_axi_wvalid & s_axi_wready;
  assign aw_have = aw_held_q | aw_hs;
  assign w_have  = w_held_q | w_hs;

  // A same-cycle handshake bypasses the holding registers so the fire is not delayed.
  assign addr_d = aw_hs ? s_axi_awaddr : awaddr_q;
  assign data_d = w_hs ? s_axi_wdata : wdata_q;
  assign strb_d = w_hs ? s_axi_wstrb : wstrb_q;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      fire_q    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else begin
      fire_q <= 1'b0;
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (aw_have && w_have) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        fire_q    <= 1'b1;
        bvalid_q  <= 1'b1;
        wr_addr_q <= addr_d;
        wr_data_q <= data_d;
        wr_strb_q <= strb_d;
      end else begin
        if (aw_hs) aw_held_q <= 1'b1;
        if (w_hs) w_held_q <= 1'b1;
        if (bvalid_q && s_axi_bready) bvalid_q <= 1'b0;
      end
    end
  end

  assign rd_en   = s_axi_arvalid & s_axi_arready;
  assign rd_addr = s_axi_araddr;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (rd_en) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axi_bvalid   = bvalid_q;
  assign s_axi_bresp    = RESP_OKAY;
  assign s_axi_rvalid   = rvalid_q;
  assign s_axi_rdata    = rdata_q;
  assign s_axi_rresp    = RESP_OKAY;
  assign axi_write_fire = fire_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign wr_strb        = wr_strb_q;

endmodule

// File: tb/tb_axi_lite_regs_if.sv
// tb/tb_axi_lite_regs_if.sv - directed self-checking bench for axi_lite_regs_if
module tb_axi_lite_regs_if;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [5:0]  awaddr, araddr, wr_addr, rd_addr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata, wr_data, rd_data;
  logic [3:0]  wstrb, wr_strb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready, fire, rd_en;

  int checks = 0;
  int errors = 0;
  int fire_cnt = 0;
  int overlap_cnt = 0;

  always #5 clk = ~clk;

  axi_lite_regs_if dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .axi_write_fire(fire), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Register block stand-in: fixed pattern per address.
  assign rd_data = (rd_addr == 6'h04) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {26'h0, rd_addr});

  always @(negedge clk) begin
    if (fire) fire_cnt++;
    if ((bvalid && (awready || wready)) || (rvalid && arready)) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input int bdelay);
    int  fires0;
    bit  aw_done, w_done, aw_n, w_n;
    fires0 = fire_cnt;
    aw_done = 0;
    w_done = 0;
    @(posedge clk); #1;
    awvalid = 1; awaddr = a;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      if (c == lead) begin
        wvalid = 1; wdata = d; wstrb = s;
      end
      @(negedge clk);
      if (aw_done && !w_done) check("aw_held_awready", awready, 0);
      aw_n = awvalid && awready;
      w_n  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_n) begin awvalid = 0; awaddr = 6'h3F; aw_done = 1; end
      if (w_n) begin wvalid = 0; wdata = 32'hFFFF_FFFF; w_done = 1; end
    end
    check("wr_handshake_done", {aw_done, w_done}, 2'b11);
    bready = (bdelay == 0);
    @(negedge clk);
    check("fire", fire, 1);
    check("wr_addr", wr_addr, a);
    check("wr_data", wr_data, d);
    check("wr_strb", wr_strb, s);
    check("bvalid_set", bvalid, 1);
    check("bresp", bresp, 2'b00);
    check("ready_during_b", {awready, wready}, 2'b00);
    for (int i = 0; i < bdelay; i++) begin
      @(posedge clk); #1;
      if (i == bdelay - 1) bready = 1;
      @(negedge clk);
      check("bvalid_hold", bvalid, 1);
      check("ready_hold_low", {awready, wready, fire}, 3'b000);
    end
    @(posedge clk); #1;
    bready = 0;
    @(negedge clk);
    check("bvalid_clear", bvalid, 0);
    check("ready_back", {awready, wready}, 2'b11);
    check("wr_data_held", wr_data, d);
    check("one_fire", fire_cnt - fires0, 1);
  endtask

  task automatic do_read(input logic [5:0] a, input logic [31:0] exp, input int rdelay);
    @(posedge clk); #1;
    arvalid = 1; araddr = a;
    @(negedge clk);
    check("rd_en", {rd_en, arready}, 2'b11);
    check("rd_addr", rd_addr, a);
    @(posedge clk); #1;
    arvalid = 0; araddr = a ^ 6'h20;
    rready = (rdelay == 0);
    @(negedge clk);
    check("rvalid_set", {rvalid, rd_en}, 2'b10);
    check("rdata", rdata, exp);
    check("rresp", rresp, 2'b00);
    for (int i = 0; i < rdelay; i++) begin
      @(posedge clk); #1;
      if (i == rdelay - 1) rready = 1;
      @(negedge clk);
      check("rvalid_hold", {rvalid, arready}, 2'b10);
      check("rdata_hold", rdata, exp);
    end
    @(posedge clk); #1;
    rready = 0;
    @(negedge clk);
    check("rvalid_clear", {rvalid, arready}, 2'b01);
  endtask

  initial begin
    aresetn = 0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", {awready, wready, arready}, 3'b000);
      check("rst_valid", {bvalid, rvalid, fire}, 3'b000);
    end
    @(posedge clk); #1;
    aresetn = 1;
    @(negedge clk);
    check("post_rst_ready", {awready, wready, arready}, 3'b111);
    check("post_rst_wr_regs", {wr_addr, wr_data, wr_strb}, 42'h0);

    do_write(6'h01, 32'h1111_0001, 4'hF, 0, 0);
    do_write(6'h08, 32'hA5A5_0F0F, 4'b0101, 3, 0);
    do_write(6'h2A, 32'h0BAD_F00D, 4'b1000, 0, 5);
    do_read(6'h04, 32'hDEAD_BEEF, 3);
    do_read(6'h10, 32'hC0DE_0010, 0);
    for (int k = 1; k <= 5; k++)
      do_write(6'(k), 32'h1111_0000 + 32'(k), 4'hF, 0, 0);

    // Reset with a half-captured write must drop it entirely.
    @(posedge clk); #1;
    awvalid = 1; awaddr = 6'h33;
    @(posedge clk); #1;
    awvalid = 0;
    aresetn = 0;
    @(posedge clk); #1;
    aresetn = 1;
    wvalid = 1; wdata = 32'h5555_AAAA; wstrb = 4'h3;
    @(posedge clk); #1;
    wvalid = 0;
    @(negedge clk);
    check("rst_drop_fire", {fire, bvalid}, 2'b00);
    check("rst_drop_awready", awready, 1);

    check("total_fires", fire_cnt, 8);
    check("ready_bvalid_overlap", overlap_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
